// File: rtl/vid_timing_gen.sv
// vid_timing_gen: raster timing generator with built-in test patterns.
// Free-running pixel/line counters drive registered sync, data-enable and
// pixel outputs, all delayed by exactly one clock from the counters.
// Optional feature: define BOUNCE_BOX_EN to overlay a 64x64 white box that
// moves diagonally by 2 px per frame and bounces off the active-area edges.
module vid_timing_gen #(
  parameter int          H_ACTIVE  = 1920,
  parameter int          H_FP      = 88,
  parameter int          H_SYNC    = 44,
  parameter int          H_BP      = 148,
  parameter int          V_ACTIVE  = 1080,
  parameter int          V_FP      = 4,
  parameter int          V_SYNC    = 5,
  parameter int          V_BP      = 36,
  parameter logic [23:0] SOLID_RGB = 24'h808080
) (
  input  logic        clk,
  input  logic        n_rst,
  input  logic        en,
  input  logic [1:0]  pattern_sel,
  output logic [23:0] o_vid_data,
  output logic        o_vid_hsync,
  output logic        o_vid_vsync,
  output logic        o_vid_VDE,
  output logic        o_frame_start,
  output logic [11:0] o_hcount,
  output logic [10:0] o_vcount
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int BAR_W   = H_ACTIVE / 8;

  localparam logic [11:0] H_LAST = 12'(H_TOTAL - 1);
  localparam logic [11:0] H_ACT  = 12'(H_ACTIVE);
  localparam logic [11:0] HS_BEG = 12'(H_ACTIVE + H_FP);
  localparam logic [11:0] HS_END = 12'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [10:0] V_LAST = 11'(V_TOTAL - 1);
  localparam logic [10:0] V_ACT  = 11'(V_ACTIVE);
  localparam logic [10:0] VS_BEG = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] VS_END = 11'(V_ACTIVE + V_FP + V_SYNC - 1);

  // Colour-bar index of a pixel column: number of bar boundaries passed.
  function automatic logic [2:0] bar_index(input logic [11:0] h);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = 1; i < 8; i++) begin
      if (32'(h) >= 32'(i * BAR_W)) begin
        idx = 3'(i);
      end else begin
        idx = idx;
      end
    end
    return idx;
  endfunction

  // Bar colours, packed as {red, blue, green}.
  function automatic logic [23:0] bar_colour(input logic [2:0] idx);
    logic [23:0] c;
    case (idx)
      3'd0:    c = 24'hFFFFFF; // white
      3'd1:    c = 24'hFF00FF; // yellow
      3'd2:    c = 24'h00FFFF; // cyan
      3'd3:    c = 24'h0000FF; // green
      3'd4:    c = 24'hFFFF00; // magenta
      3'd5:    c = 24'hFF0000; // red
      3'd6:    c = 24'h00FF00; // blue
      default: c = 24'h000000; // black
    endcase
    return c;
  endfunction

  logic [11:0] hcount_q, hcount_d;
  logic [10:0] vcount_q, vcount_d;
  logic [1:0]  pat_q, pat_d;
  logic [23:0] vid_data_q, vid_data_d;
  logic        hsync_q, hsync_d;
  logic        vsync_q, vsync_d;
  logic        vde_q, vde_d;
  logic        frame_start_q, frame_start_d;
  logic [11:0] out_hcount_q, out_hcount_d;
  logic [10:0] out_vcount_q, out_vcount_d;

  logic        frame_top_s;
  logic        active_s;
  logic [1:0]  pat_eff_s;
  logic [23:0] pix_s;
  logic        in_box_s;

  // First pixel of a frame: the moment pattern and box position are sampled.
  assign frame_top_s = (hcount_q == 12'd0) && (vcount_q == 11'd0);
  assign active_s    = (hcount_q < H_ACT) && (vcount_q < V_ACT);
  // A newly selected pattern applies from the very first pixel of its frame.
  assign pat_eff_s   = frame_top_s ? pattern_sel : pat_q;

`ifdef BOUNCE_BOX_EN
  localparam logic [11:0] BX_MAX = 12'(H_ACTIVE - 64);
  localparam logic [11:0] BY_MAX = 12'(V_ACTIVE - 64);

  // One 2-px step on an axis; returns {moving_negative, position}, clamping
  // and reversing when the step would leave [0, lim].
  function automatic logic [12:0] step_axis(input logic [11:0] pos,
                                            input logic        neg,
                                            input logic [11:0] lim);
    logic [12:0] r;
    if (!neg) begin
      if ((pos + 12'd2) > lim) r = {1'b1, lim};
      else                     r = {1'b0, pos + 12'd2};
    end else begin
      if (pos < 12'd2) r = {1'b0, 12'd0};
      else             r = {1'b1, pos - 12'd2};
    end
    return r;
  endfunction

  // bx/by hold the position for the next frame; cur_* the one on screen.
  logic [11:0] bx_q, bx_d, by_q, by_d;
  logic [11:0] cur_bx_q, cur_bx_d, cur_by_q, cur_by_d;
  logic        bx_neg_q, bx_neg_d, by_neg_q, by_neg_d;
  logic [11:0] show_bx_s, show_by_s;

  // Advance the box once per frame and decide whether this pixel is inside it.
  always_comb begin
    bx_d     = bx_q;
    by_d     = by_q;
    bx_neg_d = bx_neg_q;
    by_neg_d = by_neg_q;
    cur_bx_d = cur_bx_q;
    cur_by_d = cur_by_q;
    if (en && frame_top_s) begin
      cur_bx_d             = bx_q;
      cur_by_d             = by_q;
      {bx_neg_d, bx_d}     = step_axis(bx_q, bx_neg_q, BX_MAX);
      {by_neg_d, by_d}     = step_axis(by_q, by_neg_q, BY_MAX);
    end else begin
      cur_bx_d = cur_bx_q;
      cur_by_d = cur_by_q;
    end
    show_bx_s = frame_top_s ? bx_q : cur_bx_q;
    show_by_s = frame_top_s ? by_q : cur_by_q;
    in_box_s  = active_s &&
                ({1'b0, hcount_q} >= {1'b0, show_bx_s}) &&
                ({1'b0, hcount_q} <  ({1'b0, show_bx_s} + 13'd64)) &&
                ({2'b00, vcount_q} >= {1'b0, show_by_s}) &&
                ({2'b00, vcount_q} <  ({1'b0, show_by_s} + 13'd64));
  end

  // Box position and direction registers.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      bx_q     <= 12'd0;
      by_q     <= 12'd0;
      cur_bx_q <= 12'd0;
      cur_by_q <= 12'd0;
      bx_neg_q <= 1'b0;
      by_neg_q <= 1'b0;
    end else begin
      bx_q     <= bx_d;
      by_q     <= by_d;
      cur_bx_q <= cur_bx_d;
      cur_by_q <= cur_by_d;
      bx_neg_q <= bx_neg_d;
      by_neg_q <= by_neg_d;
    end
  end
`else
  assign in_box_s = 1'b0;
`endif

  // Pixel colour for the current counter position, box overriding the pattern.
  always_comb begin
    pix_s = 24'h000000;
    case (pat_eff_s)
      2'd0:    pix_s = bar_colour(bar_index(hcount_q));
      2'd1:    pix_s = {3{hcount_q[10:3]}};
      2'd2:    pix_s = (hcount_q[6] ^ vcount_q[6]) ? 24'hFFFFFF : 24'h000000;
      default: pix_s = SOLID_RGB;
    endcase
    if (in_box_s) begin
      pix_s = 24'hFFFFFF;
    end else begin
      pix_s = pix_s;
    end
  end

  // Counter advance and next-cycle output values; disabled means parked at 0,0.
  always_comb begin
    hcount_d      = hcount_q;
    vcount_d      = vcount_q;
    pat_d         = pat_q;
    vid_data_d    = 24'h000000;
    hsync_d       = 1'b0;
    vsync_d       = 1'b0;
    vde_d         = 1'b0;
    frame_start_d = 1'b0;
    out_hcount_d  = 12'd0;
    out_vcount_d  = 11'd0;
    if (en) begin
      pat_d = pat_eff_s;
      if (hcount_q == H_LAST) begin
        hcount_d = 12'd0;
        vcount_d = (vcount_q == V_LAST) ? 11'd0 : vcount_q + 11'd1;
      end else begin
        hcount_d = hcount_q + 12'd1;
        vcount_d = vcount_q;
      end
      out_hcount_d  = hcount_q;
      out_vcount_d  = vcount_q;
      hsync_d       = (hcount_q >= HS_BEG) && (hcount_q <= HS_END);
      vsync_d       = (vcount_q >= VS_BEG) && (vcount_q <= VS_END);
      vde_d         = active_s;
      vid_data_d    = active_s ? pix_s : 24'h000000;
      frame_start_d = frame_top_s;
    end else begin
      hcount_d = 12'd0;
      vcount_d = 11'd0;
    end
  end

  // Counter, latched pattern and output registers.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      hcount_q      <= 12'd0;
      vcount_q      <= 11'd0;
      pat_q         <= 2'd0;
      vid_data_q    <= 24'h000000;
      hsync_q       <= 1'b0;
      vsync_q       <= 1'b0;
      vde_q         <= 1'b0;
      frame_start_q <= 1'b0;
      out_hcount_q  <= 12'd0;
      out_vcount_q  <= 11'd0;
    end else begin
      hcount_q      <= hcount_d;
      vcount_q      <= vcount_d;
      pat_q         <= pat_d;
      vid_data_q    <= vid_data_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      vde_q         <= vde_d;
      frame_start_q <= frame_start_d;
      out_hcount_q  <= out_hcount_d;
      out_vcount_q  <= out_vcount_d;
    end
  end

  assign o_vid_data    = vid_data_q;
  assign o_vid_hsync   = hsync_q;
  assign o_vid_vsync   = vsync_q;
  assign o_vid_VDE     = vde_q;
  assign o_frame_start = frame_start_q;
  assign o_hcount      = out_hcount_q;
  assign o_vcount      = out_vcount_q;

endmodule

// File: tb/tb_vid_timing_gen.sv
// Testbench for vid_timing_gen using a reduced raster (108x75) so several
// whole frames fit in a short run. A frame-position reference model predicts
// every output each cycle; a coordinate table and hand sequences cover the
// pattern values, sync widths, enable gaps and mid-line reset.
module tb_vid_timing_gen;

  localparam int HA = 96, HF = 4, HS = 4, HB = 4;
  localparam int VA = 68, VF = 2, VS = 3, VB = 2;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int FT = HT * VT;
  localparam int BW = HA / 8;
  localparam logic [23:0] SOLID = 24'h808080;
  // {R,B,G}: white, yellow, cyan, green, magenta, red, blue, black
  localparam logic [23:0] BARS [8] = '{24'hFFFFFF, 24'hFF00FF, 24'h00FFFF, 24'h0000FF,
                                       24'hFFFF00, 24'hFF0000, 24'h00FF00, 24'h000000};

  logic        clk = 1'b0;
  logic        n_rst, en;
  logic [1:0]  pattern_sel;
  logic [23:0] o_vid_data;
  logic        o_vid_hsync, o_vid_vsync, o_vid_VDE, o_frame_start;
  logic [11:0] o_hcount;
  logic [10:0] o_vcount;

  vid_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB), .SOLID_RGB(SOLID)
  ) dut (
    .clk(clk), .n_rst(n_rst), .en(en), .pattern_sel(pattern_sel),
    .o_vid_data(o_vid_data), .o_vid_hsync(o_vid_hsync), .o_vid_vsync(o_vid_vsync),
    .o_vid_VDE(o_vid_VDE), .o_frame_start(o_frame_start),
    .o_hcount(o_hcount), .o_vcount(o_vcount)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [11:0] hc;
    logic [10:0] vc;
    logic        hs, vs, vde, fs;
    logic [23:0] data;
  } out_t;

  typedef struct {
    int          fr;
    int          h;
    int          v;
    logic [23:0] d;
  } vec_t;

  vec_t tbl[$];
  int   n_vec = 0, n_bad = 0;
  int   m_t = 0, m_pat = 0, m_frames = 0, m_h = 0, m_v = 0;
  bit   m_run = 1'b0;
  int   m_bx = 0, m_by = 0;
  out_t exp_o, act_o;
  int   cyc = 0, last_fs = -1, fs_seen = 0, fs_mark = 0;
  bit   fs_chk = 1'b0, tbl_on = 1'b0;
  int   hs_cnt = 0, hs_first = -1, vs_min = 9999, vs_max = -1, vs_cnt = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_vec++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s @cyc %0d: got %h, want %h", nm, cyc, act, req);
    end
  endtask

  function automatic logic [23:0] ref_pixel(input int h, input int v, input int pat);
    logic [7:0] g;
    g = 8'((h / 8) % 256);
    if (h >= HA || v >= VA) return 24'h000000;
    case (pat)
      0:       return BARS[h / BW];
      1:       return {g, g, g};
      2:       return ((((h / 64) % 2) ^ ((v / 64) % 2)) != 0) ? 24'hFFFFFF : 24'h000000;
      default: return SOLID;
    endcase
  endfunction

  // Box origin shown in frame k: k bounces of 2 px from (0,0) toward +x,+y.
  task automatic box_walk(input int k, output int x, output int y);
    int dx, dy, n;
    x = 0; y = 0; dx = 2; dy = 2;
    for (int i = 0; i < k; i++) begin
      n = x + dx;
      if (n > HA - 64) begin x = HA - 64; dx = -dx; end
      else if (n < 0) begin x = 0; dx = -dx; end
      else x = n;
      n = y + dy;
      if (n > VA - 64) begin y = VA - 64; dy = -dy; end
      else if (n < 0) begin y = 0; dy = -dy; end
      else y = n;
    end
  endtask

  task automatic add(input int fr, input int h, input int v,
                     input logic [23:0] plain, input logic [23:0] boxed);
    vec_t e;
    e.fr = fr; e.h = h; e.v = v;
`ifdef BOUNCE_BOX_EN
    e.d = boxed;
`else
    e.d = plain;
`endif
    tbl.push_back(e);
  endtask

  // One clock: advance the model with the inputs present at the edge, then compare.
  task automatic tick();
    int h, v;
    @(posedge clk);
    h = 0; v = 0; m_run = 1'b0;
    if (!n_rst) begin
      exp_o = '0; m_t = 0; m_pat = 0; m_frames = 0;
    end else if (!en) begin
      exp_o = '0; m_t = 0;
    end else begin
      m_run = 1'b1;
      h = m_t % HT;
      v = m_t / HT;
      if (m_t == 0) begin
        m_pat = int'(pattern_sel);
        box_walk(m_frames, m_bx, m_by);
        m_frames++;
      end
      exp_o.hc   = 12'(h);
      exp_o.vc   = 11'(v);
      exp_o.hs   = (h >= HA + HF) && (h < HA + HF + HS);
      exp_o.vs   = (v >= VA + VF) && (v < VA + VF + VS);
      exp_o.vde  = (h < HA) && (v < VA);
      exp_o.fs   = (m_t == 0);
      exp_o.data = ref_pixel(h, v, m_pat);
`ifdef BOUNCE_BOX_EN
      if (exp_o.vde && h >= m_bx && h < m_bx + 64 && v >= m_by && v < m_by + 64)
        exp_o.data = 24'hFFFFFF;
`endif
      m_t = (m_t + 1) % FT;
    end
    m_h = h; m_v = v;
    #1;
    cyc++;
    act_o.hc = o_hcount; act_o.vc = o_vcount; act_o.hs = o_vid_hsync;
    act_o.vs = o_vid_vsync; act_o.vde = o_vid_VDE; act_o.fs = o_frame_start;
    act_o.data = o_vid_data;
    chk("model", 64'(act_o), 64'(exp_o));
    if (tbl_on && m_run) begin
      foreach (tbl[i]) begin
        if (tbl[i].fr == m_frames - 1 && tbl[i].h == m_h && tbl[i].v == m_v)
          chk($sformatf("table_f%0d_%0d_%0d", tbl[i].fr, tbl[i].h, tbl[i].v),
              64'(o_vid_data), 64'(tbl[i].d));
      end
      if (m_frames == 1) begin
        if (o_vid_hsync && o_vcount == 11'd5) begin
          hs_cnt++;
          if (hs_first < 0) hs_first = int'(o_hcount);
        end
        if (o_vid_vsync) begin
          vs_cnt++;
          if (int'(o_vcount) < vs_min) vs_min = int'(o_vcount);
          if (int'(o_vcount) > vs_max) vs_max = int'(o_vcount);
        end
      end
    end
    if (fs_chk && o_frame_start) begin
      if (last_fs >= 0) chk("frame_interval", 64'(cyc - last_fs), 64'(FT));
      last_fs = cyc;
      fs_seen++;
    end
  endtask

  initial begin
    // frame k of the main run uses pattern k; box origin per frame: (0,0),(2,2),(4,4),(6,4)
    add(0,  0,  0, 24'hFFFFFF, 24'hFFFFFF);
    add(0, 12,  0, 24'hFF00FF, 24'hFFFFFF);
    add(0, 24,  5, 24'h00FFFF, 24'hFFFFFF);
    add(0, 36, 66, 24'h0000FF, 24'h0000FF);
    add(0, 66,  3, 24'hFF0000, 24'hFF0000);
    add(0, 95,  3, 24'h000000, 24'h000000);
    add(0,100,  3, 24'h000000, 24'h000000);
    add(0, 50, 68, 24'h000000, 24'h000000);
    add(1, 40, 10, 24'h050505, 24'hFFFFFF);
    add(1, 95,  0, 24'h0B0B0B, 24'h0B0B0B);
    add(1,  1,  1, 24'h000000, 24'h000000);
    add(2, 64,  0, 24'hFFFFFF, 24'hFFFFFF);
    add(2,  0,  0, 24'h000000, 24'h000000);
    add(2,  0, 64, 24'hFFFFFF, 24'hFFFFFF);
    add(2, 90, 64, 24'h000000, 24'h000000);
    add(2,  5,  5, 24'h000000, 24'hFFFFFF);
    add(3, 10, 10, SOLID,      24'hFFFFFF);
    add(3, 70,  4, SOLID,      SOLID);
    add(3, 69, 67, SOLID,      24'hFFFFFF);
    add(3,  5, 67, SOLID,      SOLID);

    n_rst = 1'b0; en = 1'b0; pattern_sel = 2'd0;
    repeat (3) tick();
    chk("reset_outputs_zero", 64'({o_vid_data, o_vid_hsync, o_vid_vsync, o_vid_VDE,
                                   o_frame_start, o_hcount, o_vcount}), 64'd0);
    n_rst = 1'b1;
    repeat (2) tick();

    // Four consecutive frames, switching pattern mid-frame at line 30.
    en = 1'b1; fs_chk = 1'b1; tbl_on = 1'b1;
    for (int c = 0; c < 4 * FT + 1; c++) begin
      tick();
      if (m_run && m_v == 30 && m_h == 0) pattern_sel = 2'(m_frames & 3);
    end
    tbl_on = 1'b0;
    chk("hsync_cycles_per_line", 64'(hs_cnt), 64'(HS));
    chk("hsync_first_hcount", 64'(hs_first), 64'(HA + HF));
    chk("vsync_first_line", 64'(vs_min), 64'(VA + VF));
    chk("vsync_last_line", 64'(vs_max), 64'(VA + VF + VS - 1));
    chk("vsync_cycles", 64'(vs_cnt), 64'(VS * HT));
    chk("frame_start_count", 64'(fs_seen), 64'd5);

    // Enable gap of 10 cycles mid-frame.
    for (int c = 0; c < FT; c++) begin
      tick();
      if (m_run && m_v == 30 && m_h == 10) break;
    end
    en = 1'b0; last_fs = -1;
    for (int c = 0; c < 10; c++) begin
      tick();
      chk("gap_outputs_zero", 64'({o_vid_data, o_vid_hsync, o_vid_vsync, o_vid_VDE,
                                   o_frame_start, o_hcount, o_vcount}), 64'd0);
    end
    en = 1'b1;
    fs_mark = fs_seen;
    tick();
    chk("restart_frame_start", 64'({o_frame_start, o_hcount, o_vcount}),
        64'({1'b1, 12'd0, 11'd0}));
    repeat (FT + 3) tick();
    chk("frames_after_gap", 64'(fs_seen - fs_mark), 64'd2);

    // Reset asserted mid-line.
    fs_chk = 1'b0;
    for (int c = 0; c < HT + 1; c++) begin
      tick();
      if (m_run && m_h == 50) break;
    end
    n_rst = 1'b0;
    tick();
    chk("midline_reset_zero", 64'({o_vid_data, o_vid_hsync, o_vid_vsync, o_vid_VDE,
                                   o_frame_start, o_hcount, o_vcount}), 64'd0);
    n_rst = 1'b1;
    tick();
    chk("reset_release_restart", 64'({o_frame_start, o_hcount, o_vcount}),
        64'({1'b1, 12'd0, 11'd0}));
    repeat (300) tick();

    // Randomized enables, resets and pattern selects against the model.
    for (int c = 0; c < 6000; c++) begin
      pattern_sel = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 99) == 0) en = ~en;
      else if (!en && $urandom_range(0, 7) == 0) en = 1'b1;
      n_rst = ($urandom_range(0, 1999) != 0);
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/vid_timing_gen.md
VID_TIMING_GEN -- requirements
Module: vid_timing_gen

Interface
REQ-001 The block SHALL provide parameter H_ACTIVE, default 1920, active pixels per line.
REQ-002 The block SHALL provide parameters H_FP/H_SYNC/H_BP, defaults 88/44/148, line total 2200.
REQ-003 The block SHALL provide parameter V_ACTIVE, default 1080, active lines per frame.
REQ-004 The block SHALL provide parameters V_FP/V_SYNC/V_BP, defaults 4/5/36, frame total 1125.
REQ-005 The block SHALL provide parameter SOLID_RGB, default 24'h808080, colour for pattern 3.
REQ-006 clk  input  1  pixel clock; reset n_rst, synchronous, active-low.
REQ-007 n_rst  input  1  synchronous active-low reset.
REQ-008 en  input  1  generator run enable.
REQ-009 pattern_sel  input  2  pattern select: 0 bars, 1 ramp, 2 checker, 3 solid.
REQ-010 o_vid_data  output  24  pixel, [23:16] red, [15:8] blue, [7:0] green.
REQ-011 o_vid_hsync / o_vid_vsync / o_vid_VDE  output  1 each  active-high sync and data-enable.
REQ-012 o_frame_start  output  1  one-cycle pulse coincident with first active pixel of a frame.
REQ-013 o_hcount  output  12 / o_vcount  output  11  registered counters aligned with outputs.

Function
REQ-014 hcount SHALL run 0..2199, wrapping to 0; vcount SHALL increment on hcount wrap, 0..1124, wrapping to 0.
REQ-015 Active region: hcount < H_ACTIVE and vcount < V_ACTIVE; o_vid_VDE=1 only there.
REQ-016 o_vid_hsync=1 for hcount in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1] = [2008,2051].
REQ-017 o_vid_vsync=1 for vcount in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1] = [1084,1088], full lines.
REQ-018 All outputs SHALL be registered; latency counter->outputs exactly 1 cycle, all outputs mutually aligned.
REQ-019 o_vid_data SHALL be 0 whenever o_vid_VDE=0.
REQ-020 Pattern 0: 8 vertical bars of H_ACTIVE/8 px, order white, yellow, cyan, green, magenta, red, blue, black, channel levels 8'hFF/8'h00.
REQ-021 Pattern 1: all channels = hcount[10:3] (horizontal grey ramp).
REQ-022 Pattern 2: 64x64 checker, white when hcount[6]^vcount[6]=1, else black.
REQ-023 Pattern 3: SOLID_RGB across the active region.
REQ-024 pattern_sel SHALL be latched only when hcount=0 and vcount=0; mid-frame changes take effect next frame.
REQ-025 en=0: counters held at 0, all outputs 0 from next cycle; mid-frame deassert aborts immediately.
REQ-026 en 0->1: first cycle counts hcount=0,vcount=0; pattern_sel latched then; o_frame_start pulses one cycle later.
REQ-027 o_frame_start SHALL pulse once per frame, only when en=1.

Reset
REQ-028 n_rst=0 at a rising clk edge: counters 0, all outputs 0, latched pattern 0, box state per REQ-031.
REQ-029 Reset SHALL take priority over en; release mid-frame restarts timing at hcount=0,vcount=0.

Configuration
REQ-030 Macro BOUNCE_BOX_EN SHALL compile in a moving 64x64 white box overlay.
REQ-031 With BOUNCE_BOX_EN: box origin (bx,by) resets to (0,0), direction +x,+y; updated once per frame at hcount=0,vcount=0 by +/-2 per axis.
REQ-032 Direction reverses on an axis when the next step would exceed bx 1856 or by 1016 or go below 0; the position is clamped at the limit for that frame.
REQ-033 Box pixels (bx<=hcount<bx+64, by<=vcount<by+64, active) SHALL output 24'hFFFFFF, overriding the pattern.
REQ-034 Without BOUNCE_BOX_EN: no box logic, no box state registers, output is pattern only.

Verification
REQ-035 Reset, en=1, run 2 frames -> hsync high 44 cycles/line starting at o_hcount=2008; vsync high lines 1084-1088; 2200x1125 cycles between o_frame_start pulses.
REQ-036 pattern_sel=0 -> pixel at o_hcount=0 is 24'hFFFFFF, at 240 is 24'hFF00FF (yellow: R=FF,B=00,G=FF), at 1919 is 0; at 2000 is 0 with VDE=0.
REQ-037 pattern_sel 0->2 at o_vcount=500 -> current frame stays bars; next frame pixel (64,0)=24'hFFFFFF, (0,0)=0.
REQ-038 en dropped at o_vcount=300 for 10 cycles, then raised -> outputs 0 during gap; o_frame_start pulses 1 cycle after re-raise; full frame timing resumes.
REQ-039 BOUNCE_BOX_EN, pattern 3 -> frame 0 box at (0,0): pixel (63,63)=24'hFFFFFF, (64,0)=24'h808080; frame 1 box at (2,2).
REQ-040 n_rst asserted mid-line at o_hcount=1000 -> next cycle all outputs 0; after release, counting restarts at 0,0.
